mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Controller that computes one IEEE-754 single-precision dot product on a shared, externally instantiated pipelined floating-point MAC (q = a*b + c, latency LAT enabled cycles).
- Hides the MAC feedback latency by keeping LAT interleaved partial sums in flight inside the MAC pipeline.
- Once the vectors are consumed, it reduces those partial sums pairwise through the same MAC, using b = 1.0.
- Sits between a vector-element stream source and a result consumer.

Parameters:
LAT, 9, MAC latency in enabled cycles; must be >= 2.
LW, 16, width of the vector-length field.

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  begin a dot product; sampled only in IDLE
len  in  LW  element count, captured on accepted start
busy  out  1  high in every state except IDLE
in_valid  in  1  element pair valid
in_ready  out  1  element pair accepted when in_valid && in_ready
in_a  in  32  float operand A
in_b  in  32  float operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  32  float dot-product result
mac_en  out  1  MAC pipeline enable; pipeline holds when low
mac_a  out  32  MAC operand a
mac_b  out  32  MAC operand b
mac_c  out  32  MAC addend c
mac_q  in  32  MAC result; the op issued LAT enabled cycles earlier, held while mac_en is low

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; busy=0, in_ready=0, out_valid=0, out_data=0, mac_en=0, mac_a=mac_b=mac_c=0; all counters, the hold register and the slot-valid shift register are cleared. Reset mid-operation aborts the product and produces no output. The MAC's own areset is tied to !resetn at top level.
- Issue counter k counts mac_en cycles in ACCUM/FILL.
- slot_v is a LAT-bit shift register that advances only when mac_en=1 and mirrors which pipeline slots carry live values.
- IDLE: on start=1, capture len, k=0 -> ACCUM. start in any other state is ignored.
- ACCUM:
  - in_ready=1 while k<len.
  - On handshake: mac_en=1, mac_a=in_a, mac_b=in_b, mac_c = (k<LAT) ? 0 : mac_q; k++.
  - With no handshake: mac_en=0, so the pipeline freezes and feedback alignment is preserved.
  - When k==len -> FILL. len=0 goes to FILL immediately after start.
- FILL: while k<LAT, issue a=0, b=0, c=0, mac_en=1 each cycle; k++. When k>=LAT -> REDUCE with remaining-value count R=LAT and the hold register empty.
- REDUCE:
  - mac_en=1 every cycle; mac_b=32'h3F800000.
  - Emerging value: slot_v output bit set, with the value on mac_q.
  - If hold is empty, capture mac_q into hold and issue a bubble (a=c=0, slot bit 0).
  - If hold is full, issue a=hold, c=mac_q, slot bit 1; clear hold; R--.
  - No emerging value: bubble.
  - When R==1, hold is full and no slot is live -> DONE, out_data=hold.
  - Reduction completes in at most LAT*(ceil(log2 LAT)+1) cycles.
- DONE: out_valid=1, out_data stable until out_ready=1 -> IDLE, out_valid=0.
- The result is exactly what this MAC association order produces. It is not bit-matched to a sequential sum except when all partial sums are exactly representable.
- Result for len=0 is +0.0 (32'h00000000).
- in_ready=0 outside ACCUM. mac_en=0 in IDLE and DONE.

Test Plan:
- Reset: resetn=0 for 3 cycles mid-ACCUM, then release -> all outputs 0, state IDLE; a following len=4 product completes correctly.
- len=4, A=1.0 (3F800000), B=2.0 (40000000), in_valid held high -> in_ready high exactly 4 cycles; out_data=41000000 (8.0).
- len=20, A=1.0..20.0, B=1.0, in_valid randomly toggled -> out_data=43520000 (210.0); mac_en never high in ACCUM without a handshake.
- len=0 -> no in_ready; FILL issues LAT zero ops; out_data=00000000.
- len=9 (==LAT) and len=10 (LAT+1), all A=B=1.0 -> 41100000 (9.0) and 41200000 (10.0); checks the c-select switchover at k=LAT.
- out_ready held low 50 cycles in DONE -> out_valid and out_data stable; start pulses ignored; busy=1 until the accept cycle.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Dot-product controller for a shared pipelined float MAC: interleaves LAT partial sums
// through the MAC pipeline, then folds them pairwise through the same MAC with b = 1.0.
module mac_dot_sequencer #(
  parameter int unsigned LAT = 9,
  parameter int unsigned LW  = 16
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          mac_en,
  output logic [31:0]   mac_a,
  output logic [31:0]   mac_b,
  output logic [31:0]   mac_c,
  input  logic [31:0]   mac_q
);

  localparam int unsigned FW = 32;
  localparam int unsigned RW = $clog2(LAT + 1);
  localparam logic [FW-1:0] ONE_F = 32'h3F80_0000;
  localparam logic [LW-1:0] LAT_K = LW'(LAT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCUM  = 3'd1,
    S_FILL   = 3'd2,
    S_REDUCE = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   k_q, k_d;
  logic [LW-1:0]   len_q, len_d;
  logic [RW-1:0]   r_q, r_d;
  logic [FW-1:0]   hold_q, hold_d;
  logic            hold_v_q, hold_v_d;
  logic [LAT-1:0]  slot_v_q, slot_v_d;
  logic            busy_q, out_valid_q;
  logic [FW-1:0]   out_data_q, out_data_d;

  logic            hs_c;
  logic            slot_in_c;
  logic            capture_c;
  logic            combine_c;
  logic            done_c;

  // Final value sits alone in hold once every other partial sum has been folded in.
  assign done_c = (r_q == RW'(1)) && hold_v_q && (slot_v_q == '0);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = (len == '0) ? S_FILL : S_ACCUM;
      S_ACCUM:  if (hs_c && ((k_q + LW'(1)) == len_q)) state_d = S_FILL;
      S_FILL:   if (k_q >= (LAT_K - LW'(1))) state_d = S_REDUCE;
      S_REDUCE: if (done_c) state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // MAC issue and handshake decode
  always_comb begin
    in_ready  = 1'b0;
    hs_c      = 1'b0;
    mac_en    = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    mac_c     = '0;
    slot_in_c = 1'b0;
    capture_c = 1'b0;
    combine_c = 1'b0;
    unique case (state_q)
      S_ACCUM: begin
        in_ready = (k_q < len_q);
        hs_c     = in_valid && (k_q < len_q);
        if (hs_c) begin
          mac_en    = 1'b1;
          mac_a     = in_a;
          mac_b     = in_b;
          mac_c     = (k_q < LAT_K) ? '0 : mac_q;
          slot_in_c = 1'b1;
        end
      end
      S_FILL: begin
        if (k_q < LAT_K) begin
          mac_en    = 1'b1;
          slot_in_c = 1'b1;
        end
      end
      S_REDUCE: begin
        mac_en = 1'b1;
        mac_b  = ONE_F;
        if (slot_v_q[LAT-1]) begin
          if (hold_v_q) begin
            combine_c = 1'b1;
            mac_a     = hold_q;
            mac_c     = mac_q;
            slot_in_c = 1'b1;
          end else begin
            capture_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    k_d        = k_q;
    len_d      = len_q;
    r_d        = r_q;
    hold_d     = hold_q;
    hold_v_d   = hold_v_q;
    slot_v_d   = slot_v_q;
    out_data_d = out_data_q;
    if ((state_q == S_IDLE) && start) begin
      len_d    = len;
      k_d      = '0;
      slot_v_d = '0;
    end
    if (mac_en && ((state_q == S_ACCUM) || (state_q == S_FILL))) k_d = k_q + LW'(1);
    // Slot tracking advances in lockstep with the MAC pipeline.
    if (mac_en) slot_v_d = {slot_v_q[LAT-2:0], slot_in_c};
    if ((state_q == S_FILL) && (state_d == S_REDUCE)) begin
      r_d      = RW'(LAT);
      hold_v_d = 1'b0;
    end
    if (capture_c) begin
      hold_d   = mac_q;
      hold_v_d = 1'b1;
    end
    if (combine_c) begin
      hold_v_d = 1'b0;
      r_d      = r_q - RW'(1);
    end
    if ((state_q == S_REDUCE) && (state_d == S_DONE)) out_data_d = hold_q;
  end

  // Datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      k_q        <= '0;
      len_q      <= '0;
      r_q        <= '0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      slot_v_q   <= '0;
      out_data_q <= '0;
    end else begin
      k_q        <= k_d;
      len_q      <= len_d;
      r_q        <= r_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      slot_v_q   <= slot_v_d;
      out_data_q <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural float MAC pipeline, real-valued dot-product
// reference, per-cycle protocol monitor and directed products with literal results.
module tb_mac_dot_sequencer;

  localparam int LAT = 9;
  localparam int LW  = 16;
  localparam logic [31:0] ONE_F = 32'h3F80_0000;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic          mac_en;
  logic [31:0]   mac_a, mac_b, mac_c, mac_q;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_res = '0;
  int          hs_cnt = 0;
  int          fill_cnt = 0;
  logic        prev_ov = 1'b0;
  logic [31:0] prev_od = '0;
  logic [31:0] va [32];
  logic [31:0] vb [32];
  logic [31:0] pipe [LAT];

  always #5 clock = ~clock;

  mac_dot_sequencer #(.LAT(LAT), .LW(LW)) dut (
    .clock(clock), .resetn(resetn), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_q(mac_q)
  );

  function automatic real f2r(input logic [31:0] f);
    real m, p;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    p = 1.0;
    if (e > 0) repeat (e) p = p * 2.0;
    else repeat (-e) p = p / 2.0;
    return f[31] ? -(m * p) : (m * p);
  endfunction

  function automatic logic [31:0] r2f(input real r_in);
    real   r;
    int    e;
    logic  s;
    longint mant;
    if (r_in == 0.0) return 32'h0;
    s = (r_in < 0.0);
    r = s ? -r_in : r_in;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    mant = longint'((r - 1.0) * 8388608.0);
    return {s, 8'(e), 23'(mant)};
  endfunction

  // External MAC: q = a*b + c, LAT enabled cycles deep, cleared by !resetn.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (mac_en) begin
      pipe[0] <= r2f(f2r(mac_a) * f2r(mac_b) + f2r(mac_c));
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mac_q = pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle protocol and result monitor
  always begin
    @(negedge clock);
    #2;
    if (resetn) begin
      if (!busy) begin
        hs_cnt   = 0;
        fill_cnt = 0;
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_mac_en", 32'(mac_en), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
      end
      if (in_ready) begin
        check("issue_iff_handshake", 32'(mac_en), 32'(in_valid));
        if (in_valid) begin
          check("issue_a", mac_a, in_a);
          check("issue_b", mac_b, in_b);
          check("issue_c", mac_c, (hs_cnt < LAT) ? 32'h0 : mac_q);
          hs_cnt++;
        end
      end
      if (mac_en && !in_ready && mac_b == 32'h0) fill_cnt++;
      if (out_valid) begin
        check("done_busy", 32'(busy), 32'd1);
        check("result_model", out_data, exp_res);
        if (prev_ov) check("result_stable", out_data, prev_od);
      end
      prev_ov = out_valid;
      prev_od = out_data;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic set_vec(input int n, input int kind);
    for (int i = 0; i < 32; i++) begin
      case (kind)
        0:       begin va[i] = r2f(1.0); vb[i] = r2f(2.0); end
        1:       begin va[i] = r2f(real'(i + 1)); vb[i] = r2f(1.0); end
        default: begin va[i] = r2f(1.0); vb[i] = r2f(1.0); end
      endcase
    end
    exp_res = 32'h0;
    begin
      real s;
      s = 0.0;
      for (int i = 0; i < n; i++) s = s + f2r(va[i]) * f2r(vb[i]);
      exp_res = r2f(s);
    end
  endtask

  task automatic run_op(input int n, input bit rnd, input int hold_cyc, input logic [31:0] exp_lit);
    int i, cyc, rdy;
    @(negedge clock);
    start = 1'b1;
    len   = LW'(n);
    @(negedge clock);
    start = 1'b0;
    #1 check("busy_after_start", 32'(busy), 32'd1);
    i = 0; cyc = 0; rdy = 0;
    while (i < n && cyc < 500) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_a = va[i];
      in_b = vb[i];
      #1;
      if (in_ready) rdy++;
      if (in_valid && in_ready) i++;
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    #1;
    cyc = 0;
    while (!out_valid && cyc < 500) begin
      if (in_ready) rdy++;
      @(negedge clock);
      #1;
      cyc++;
    end
    check("result_arrives", 32'(out_valid), 32'd1);
    if (!rnd) check("ready_cycles", 32'(rdy), 32'(n));
    check("handshakes", 32'(hs_cnt), 32'(n));
    check("fill_ops", 32'(fill_cnt), 32'((n < LAT) ? LAT - n : 0));
    for (int j = 0; j < hold_cyc; j++) begin
      @(negedge clock);
      start = (j % 7 == 3);
      len   = LW'(j);
      #1;
      check("held_valid", 32'(out_valid), 32'd1);
      check("held_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    check("result_literal", out_data, exp_lit);
    @(negedge clock);
    out_ready = 1'b1;
    #1 check("busy_on_accept", 32'(busy), 32'd1);
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    check("idle_after_accept_busy", 32'(busy), 32'd0);
    check("idle_after_accept_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_mac_a", mac_a, 32'h0);
    check("rst_mac_b", mac_b, 32'h0);
    check("rst_mac_c", mac_c, 32'h0);
  endtask

  initial begin
    // Pin the reference arithmetic itself.
    check("model_one", r2f(1.0), 32'h3F80_0000);
    check("model_210", r2f(210.0), 32'h4352_0000);
    check("model_mac", r2f(f2r(32'h4000_0000) * f2r(ONE_F) + f2r(32'h40C0_0000)), 32'h4100_0000);

    repeat (3) @(negedge clock);
    #1 check_reset_outputs();
    resetn = 1'b1;

    // Abort mid-accumulation with a 3-cycle reset.
    set_vec(20, 1);
    @(negedge clock);
    start = 1'b1;
    len   = LW'(20);
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = va[i];
      in_b = vb[i];
      @(negedge clock);
    end
    resetn = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check_reset_outputs();
      @(negedge clock);
    end
    resetn = 1'b1;
    #1 check_reset_outputs();

    set_vec(4, 0);
    run_op(4, 1'b0, 0, 32'h4100_0000);
    set_vec(4, 0);
    run_op(4, 1'b0, 0, 32'h4100_0000);
    set_vec(20, 1);
    run_op(20, 1'b1, 0, 32'h4352_0000);
    set_vec(0, 2);
    run_op(0, 1'b0, 0, 32'h0000_0000);
    set_vec(9, 2);
    run_op(9, 1'b0, 0, 32'h4110_0000);
    set_vec(10, 2);
    run_op(10, 1'b0, 0, 32'h4120_0000);
    set_vec(10, 2);
    run_op(10, 1'b1, 50, 32'h4120_0000);

    repeat (3) @(negedge clock);
    #1 check("final_idle", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
